mac_accum: RTL and testbench

//  Downstream stage of the 8x8 multiplier in the conv datapath. Consumes a stream of
//  16-bit unsigned products, sums KERNEL_LEN of them and adds a bias. Requantizes the
//  sum to an OUT_W-bit unsigned activation (right shift plus saturation) and emits it

---
 rtl/mac_accum.sv | 121 ++++++++++++
 tb/tb_mac_accum.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mac_accum.sv
// mac_accum: sums KERNEL_LEN unsigned 16-bit products, adds a bias, then
// requantizes the total to an OUT_W-bit activation by right shift with saturation.
// Optional feature macro: MAC_ACCUM_ROUND_EN (round half up before saturation).
module mac_accum #(
    parameter int KERNEL_LEN = 9,
    parameter int ACC_W      = 24,
    parameter int SHIFT      = 8,
    parameter int OUT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_prod_valid,
    input  logic [15:0]      i_prod_in,
    input  logic [15:0]      i_bias,
    output logic             o_in_ready,
    output logic [OUT_W-1:0] o_out_data,
    output logic             o_out_valid,
    output logic             o_busy,
    output logic             o_overrun
);

    localparam int CNT_W = $clog2(KERNEL_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(KERNEL_LEN);
`ifdef MAC_ACCUM_ROUND_EN
    // One extra bit of headroom so the bias add plus the rounding constant cannot wrap
    localparam int S_W = ACC_W + 2;
    localparam logic [S_W-1:0] HALF = S_W'(64'd1 << (SHIFT - 1));
`else
    localparam int S_W = ACC_W + 1;
`endif
    localparam logic [S_W-1:0] MAXV = S_W'((64'd1 << OUT_W) - 64'd1);

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS} state_t;

    state_t           r_state, w_next;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept, w_drop;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [ACC_W:0]   w_acc_sum;
    logic [ACC_W-1:0] w_acc_sat;
    logic [S_W-1:0]   w_s, w_r;
    logic [OUT_W-1:0] w_q;

    assign o_in_ready = (r_state != BIAS);
    assign o_busy     = (r_state != IDLE);
    assign w_accept   = i_prod_valid & o_in_ready;
    assign w_drop     = i_prod_valid & ~o_in_ready;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // Accumulation clamps at all-ones instead of wrapping
    assign w_acc_sum = {1'b0, r_acc} + (ACC_W+1)'(i_prod_in);
    assign w_acc_sat = w_acc_sum[ACC_W] ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];

`ifdef MAC_ACCUM_ROUND_EN
    assign w_s = S_W'(r_acc) + S_W'(i_bias) + HALF;
`else
    assign w_s = S_W'(r_acc) + S_W'(i_bias);
`endif
    assign w_r = w_s >> SHIFT;
    assign w_q = (w_r > MAXV) ? {OUT_W{1'b1}} : w_r[OUT_W-1:0];

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; clear always returns to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (KERNEL_LEN == 1) ? BIAS : ACCUM;
            ACCUM:   if (w_accept && (w_cnt_inc == LAST)) w_next = BIAS;
            BIAS:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (i_clear) w_next = IDLE;
    end

    // Datapath: accumulate, requantize in BIAS, sticky overrun; clear wins over accept
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            o_out_data  <= '0;
            o_out_valid <= 1'b0;
            o_overrun   <= 1'b0;
        end else if (i_clear) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            o_out_valid <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_out_valid <= 1'b0;
            if (w_drop) o_overrun <= 1'b1;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_acc <= ACC_W'(i_prod_in);
                    r_cnt <= CNT_W'(1);
                end
                ACCUM: if (w_accept) begin
                    r_acc <= w_acc_sat;
                    r_cnt <= w_cnt_inc;
                end
                BIAS: begin
                    o_out_data  <= w_q;
                    o_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end
                default: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// Self-checking bench for mac_accum: directed table, multi-cycle corner
// sequences and randomized kernels against an arithmetic reference model.
module tb_mac_accum;

    localparam int KL = 9;
    localparam int SH = 8;
`ifdef MAC_ACCUM_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, clear, pv;
    logic [15:0] pin, bias;
    logic        in_ready, out_valid, busy, overrun;
    logic [7:0]  out_data;

    mac_accum dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_prod_valid(pv),
        .i_prod_in(pin), .i_bias(bias), .o_in_ready(in_ready),
        .o_out_data(out_data), .o_out_valid(out_valid), .o_busy(busy),
        .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int q[$];
    logic [15:0] kp [KL];

    typedef struct {
        logic [15:0] val;
        logic [15:0] b;
        int          exp_t;
        int          exp_r;
    } vec_t;
    vec_t tv[7];

    // Capture every output strobe away from the active edge
    always @(negedge clk) if (out_valid) q.push_back(int'(out_data));

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: sum + bias, optional round-half-up, shift, clamp to 255
    function automatic int model(input longint sum, input longint b);
        longint s;
        s = sum + b;
        if (RND) s = s + (longint'(1) << (SH - 1));
        s = s >>> SH;
        return (s > 255) ? 255 : int'(s);
    endfunction

    task automatic present(input logic [15:0] v, input int gap);
        pv = 1'b0;
        repeat (gap) @(negedge clk);
        pv  = 1'b1;
        pin = v;
        @(negedge clk);
        pv = 1'b0;
    endtask

    task automatic kernel_check(input string nm, input int maxgap, input logic [15:0] b, input int exp);
        q.delete();
        bias = b;
        for (int i = 0; i < KL; i++) present(kp[i], int'($urandom_range(maxgap, 0)));
        repeat (3) @(negedge clk);
        chk({nm, "_count"}, q.size(), 1);
        chk({nm, "_data"}, (q.size() > 0) ? q[0] : -1, exp);
    endtask

    initial begin
        longint sum;
        logic [15:0] rb;
        tv[0] = '{16'd100,   16'd0,     3,   4};
        tv[1] = '{16'd65535, 16'd65535, 255, 255};
        tv[2] = '{16'd256,   16'd0,     9,   9};
        tv[3] = '{16'd0,     16'd0,     0,   0};
        tv[4] = '{16'd28,    16'd0,     0,   1};
        tv[5] = '{16'd7253,  16'd2,     254, 255};
        tv[6] = '{16'd7281,  16'd7,     255, 255};

        rst = 1'b1; clear = 1'b0; pv = 1'b0; pin = '0; bias = '0;
        #12;
        chk("rst_data", out_data, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_overrun", overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Latency and strobe width on back-to-back 9x100
        q.delete();
        for (int i = 0; i < KL; i++) present(16'd100, 0);
        chk("lat_valid_k", out_valid, 0);
        chk("lat_busy_k", busy, 1);
        chk("lat_ready_bias", in_ready, 0);
        @(negedge clk);
        chk("lat_valid_k1", out_valid, 1);
        chk("lat_data", out_data, RND ? 4 : 3);
        chk("lat_idle", busy, 0);
        @(negedge clk);
        chk("lat_valid_k2", out_valid, 0);
        repeat (2) @(negedge clk);
        chk("lat_count", q.size(), 1);

        // Directed table
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < KL; i++) kp[i] = tv[t].val;
            kernel_check($sformatf("tab%0d", t), 0, tv[t].b, RND ? tv[t].exp_r : tv[t].exp_t);
            chk($sformatf("tab%0d_ovr", t), overrun, 0);
        end

        // Product held valid through BIAS gets dropped and flags overrun
        q.delete();
        bias = 16'd0;
        pv = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pin = (i < 9) ? 16'd100 : 16'd7;
            @(negedge clk);
        end
        pv = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovr_count", q.size(), 1);
        chk("ovr_data", (q.size() > 0) ? q[0] : -1, model(900, 0));
        chk("ovr_flag", overrun, 1);
        for (int i = 0; i < KL; i++) kp[i] = 16'd256;
        kernel_check("ovr_next", 0, 16'd0, 9);
        chk("ovr_sticky", overrun, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("ovr_clear", overrun, 0);

        // Async reset mid-kernel, between clock edges
        for (int i = 0; i < 4; i++) present(16'd1000, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_data", out_data, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_overrun", overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < KL; i++) kp[i] = 16'd512;
        kernel_check("arst_next", 3, 16'd0, 18);

        // clear coincident with the 9th accept suppresses the output
        q.delete();
        bias = 16'd0;
        for (int i = 0; i < 8; i++) present(16'd100, 0);
        clear = 1'b1; pv = 1'b1; pin = 16'd100;
        @(negedge clk);
        clear = 1'b0; pv = 1'b0;
        repeat (4) @(negedge clk);
        chk("clr_count", q.size(), 0);
        chk("clr_busy", busy, 0);
        for (int i = 0; i < KL; i++) kp[i] = 16'd100;
        kernel_check("clr_next", 1, 16'd0, model(900, 0));

        // Randomized kernels with random gaps
        for (int k = 0; k < 25; k++) begin
            sum = 0;
            for (int i = 0; i < KL; i++) begin
                kp[i] = ($urandom_range(1, 0) == 1) ? 16'($urandom_range(2000, 0))
                                                   : 16'($urandom_range(65535, 0));
                sum += longint'(kp[i]);
            end
            rb = 16'($urandom_range(65535, 0));
            kernel_check($sformatf("rand%0d", k), 2, rb, model(sum, longint'(rb)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
